// File: rtl/cache_port_arbiter.sv
// Shares one single-ported cache between the instruction-fetch port and the data port.
// Optional build macro ROUND_ROBIN_EN: alternate grants on contention instead of data-first.
module cache_port_arbiter #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic        I_ACK,
    output logic [31:0] I_DATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_DIN,
    output logic        D_ACK,
    output logic [31:0] D_DATA,
    output logic        ERR,
    output logic [31:0] C_ADDR,
    output logic [31:0] C_DIN,
    output logic        C_WE,
    input  logic [31:0] C_DOUT,
    input  logic        C_RDY,
    output logic        BUSY
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [7:0] TMO_LIMIT   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT,
        ST_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        sel_d_q, sel_d_d;
    logic        we_q, we_d;
    logic        wr_done_q, wr_done_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;
    logic [31:0] i_data_q, i_data_d;
    logic [31:0] d_data_q, d_data_d;
    logic [31:0] c_addr_q, c_addr_d;
    logic [31:0] c_din_q, c_din_d;
    logic        c_we_q, c_we_d;
    logic        busy_q, busy_d;
`ifdef ROUND_ROBIN_EN
    logic        rr_last_d_q, rr_last_d_d;
`endif

    logic i_ok, d_ok, pick_d;

    // A port acknowledged last cycle still shows its old REQ; ignore it for one cycle.
    always_comb begin
        i_ok = I_REQ && !i_ack_q;
        d_ok = D_REQ && !d_ack_q;
`ifdef ROUND_ROBIN_EN
        if (i_ok && d_ok) begin
            pick_d = !rr_last_d_q;
        end else begin
            pick_d = d_ok;
        end
`else
        pick_d = d_ok;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        sel_d_d   = sel_d_q;
        we_d      = we_q;
        wr_done_d = wr_done_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        i_data_d  = i_data_q;
        d_data_d  = d_data_q;
        c_addr_d  = c_addr_q;
        c_din_d   = c_din_q;
        c_we_d    = 1'b0;
`ifdef ROUND_ROBIN_EN
        rr_last_d_d = rr_last_d_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_ok || d_ok) begin
                    sel_d_d   = pick_d;
                    we_d      = pick_d && D_WE;
                    wr_done_d = 1'b0;
                    c_addr_d  = pick_d ? D_ADDR : I_ADDR;
                    if (pick_d) begin
                        c_din_d = D_DIN;
                    end
                    cnt_d   = SETTLE_INIT;
                    state_d = ST_SETTLE;
`ifdef ROUND_ROBIN_EN
                    rr_last_d_d = pick_d;
`endif
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    tmo_d   = 8'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (C_RDY) begin
                    if (we_q && !wr_done_q) begin
                        c_we_d  = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        if (sel_d_q) begin
                            d_ack_d = 1'b1;
                            if (!we_q) begin
                                d_data_d = C_DOUT;
                            end
                        end else begin
                            i_ack_d  = 1'b1;
                            i_data_d = C_DOUT;
                        end
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LIMIT) begin
                    i_ack_d = !sel_d_q;
                    d_ack_d = sel_d_q;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_WRITE: begin
                // Go back through settle so the ACK waits for RDY after the write lands.
                wr_done_d = 1'b1;
                cnt_d     = SETTLE_INIT;
                state_d   = ST_SETTLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            tmo_q     <= 8'd0;
            sel_d_q   <= 1'b0;
            we_q      <= 1'b0;
            wr_done_q <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            i_data_q  <= 32'd0;
            d_data_q  <= 32'd0;
            c_addr_q  <= 32'd0;
            c_din_q   <= 32'd0;
            c_we_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rr_last_d_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            sel_d_q   <= sel_d_d;
            we_q      <= we_d;
            wr_done_q <= wr_done_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            i_data_q  <= i_data_d;
            d_data_q  <= d_data_d;
            c_addr_q  <= c_addr_d;
            c_din_q   <= c_din_d;
            c_we_q    <= c_we_d;
            busy_q    <= busy_d;
`ifdef ROUND_ROBIN_EN
            rr_last_d_q <= rr_last_d_d;
`endif
        end
    end

    assign I_ACK  = i_ack_q;
    assign I_DATA = i_data_q;
    assign D_ACK  = d_ack_q;
    assign D_DATA = d_data_q;
    assign ERR    = err_q;
    assign C_ADDR = c_addr_q;
    assign C_DIN  = c_din_q;
    assign C_WE   = c_we_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter with a small cache model (addresses ending 2'b11 miss).
module tb_cache_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ, D_REQ, D_WE;
    logic [31:0] I_ADDR, D_ADDR, D_DIN;
    logic        I_ACK, D_ACK, ERR, C_WE, C_RDY, BUSY;
    logic [31:0] I_DATA, D_DATA, C_ADDR, C_DIN, C_DOUT;

    int total = 0;
    int bad = 0;
    int cwe_cnt = 0;

    always #5 CLK = ~CLK;

    cache_port_arbiter #(.SETTLE_CYCLES(1), .TIMEOUT(255)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_DATA(I_DATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_DIN(D_DIN),
        .D_ACK(D_ACK), .D_DATA(D_DATA), .ERR(ERR),
        .C_ADDR(C_ADDR), .C_DIN(C_DIN), .C_WE(C_WE), .C_DOUT(C_DOUT),
        .C_RDY(C_RDY), .BUSY(BUSY)
    );

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {16'hCAFE, a[15:0]};
    endfunction

    function automatic int miss_lat(input logic [31:0] a);
        return (a[1:0] == 2'b11) ? 3 : 0;
    endfunction

    // Cache model: RDY goes low when the address changes, returns after the miss latency.
    bit          wr_v [32];
    logic [31:0] wr_m [32];
    logic [31:0] last_a = '1;
    int          dly = 0;
    bit          force_low = 1'b0;

    always @(posedge CLK) begin
        if (C_WE) begin
            wr_v[C_ADDR[4:0]] <= 1'b1;
            wr_m[C_ADDR[4:0]] <= C_DIN;
            dly <= 1;
        end else if (C_ADDR !== last_a) begin
            last_a <= C_ADDR;
            dly <= miss_lat(C_ADDR);
        end else if (dly > 0) begin
            dly <= dly - 1;
        end
    end

    assign C_DOUT = wr_v[C_ADDR[4:0]] ? wr_m[C_ADDR[4:0]] : init_val(C_ADDR);
    assign C_RDY  = !force_low && (C_ADDR === last_a) && (dly == 0);

    // Reference memory kept by the bench from the writes it issues.
    bit          ref_v [32];
    logic [31:0] ref_m [32];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_v[a[4:0]] ? ref_m[a[4:0]] : init_val(a);
    endfunction

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] i_data_exp = 32'd0;
    logic [31:0] d_data_exp = 32'd0;

    always @(negedge CLK) begin
        if (C_WE === 1'b1) cwe_cnt++;
        if (I_ACK || D_ACK || ERR) begin
            total++;
            if ((I_ACK && D_ACK) || (ERR && !(I_ACK || D_ACK))) begin
                bad++;
                $display("FAIL ack_excl: I_ACK=%b D_ACK=%b ERR=%b, required one ACK only", I_ACK, D_ACK, ERR);
            end
        end
    end

    task automatic access(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] din,
                          output bit got, output int lat, output bit o_i, output bit o_d,
                          output bit o_err, output logic [31:0] o_idata, output logic [31:0] o_ddata);
        if (is_d) begin
            D_REQ = 1'b1; D_WE = we; D_ADDR = addr; D_DIN = din;
        end else begin
            I_REQ = 1'b1; I_ADDR = addr;
        end
        got = 1'b0; lat = 0; o_i = 1'b0; o_d = 1'b0; o_err = 1'b0;
        o_idata = 32'd0; o_ddata = 32'd0;
        for (int k = 1; k <= 400 && !got; k++) begin
            @(negedge CLK);
            if (k == 2) begin
                I_ADDR = I_ADDR ^ 32'h10;
                D_ADDR = D_ADDR ^ 32'h10;
                D_DIN  = ~D_DIN;
                D_WE   = ~D_WE;
            end
            if (I_ACK || D_ACK) begin
                got = 1'b1; lat = k; o_i = I_ACK; o_d = D_ACK; o_err = ERR;
                o_idata = I_DATA; o_ddata = D_DATA;
            end
        end
        if (is_d) D_REQ = 1'b0; else I_REQ = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] outs [9];
        string names [9];
        int c0;
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        outs[0] = 32'(I_ACK); outs[1] = I_DATA; outs[2] = 32'(D_ACK); outs[3] = D_DATA;
        outs[4] = 32'(ERR); outs[5] = C_ADDR; outs[6] = C_DIN; outs[7] = 32'(C_WE); outs[8] = 32'(BUSY);
        names = '{"I_ACK", "I_DATA", "D_ACK", "D_DATA", "ERR", "C_ADDR", "C_DIN", "C_WE", "BUSY"};
        for (int i = 0; i < 9; i++) begin
            total++;
            if (outs[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_%s: got %h, required 0", names[i], outs[i]);
            end
        end
        RST = 1'b0;
        c0 = cwe_cnt;
        repeat (10) @(negedge CLK);
        total++;
        if (cwe_cnt !== c0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_we: C_WE pulses=%0d BUSY=%b, required 0 and 0", cwe_cnt - c0, BUSY);
        end
    endtask

    task automatic test_contention();
        exp_t e, f;
        bit   first_d;
        int   n;
`ifdef ROUND_ROBIN_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        for (int p = 0; p < 10; p++) begin
            @(negedge CLK);
            e.is_d = first_d;  e.data = first_d ? ref_rd(3) : ref_rd(2); e.err = 1'b0; e.lat = 0;
            exp_q.push_back(e);
            e.is_d = !first_d; e.data = first_d ? ref_rd(2) : ref_rd(3);
            exp_q.push_back(e);
            I_REQ = 1'b1; I_ADDR = 32'd2;
            D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'd3; D_DIN = 32'd0;
            n = 0;
            for (int k = 0; k < 80 && n < 2; k++) begin
                @(negedge CLK);
                if (I_ACK || D_ACK) begin
                    f = exp_q.pop_front();
                    n++;
                    total++;
                    if (D_ACK !== f.is_d || (f.is_d ? D_DATA : I_DATA) !== f.data) begin
                        bad++;
                        $display("FAIL contention_pair%0d_ack%0d: D_ACK=%b data=%h, required D_ACK=%b data=%h",
                                 p, n, D_ACK, f.is_d ? D_DATA : I_DATA, f.is_d, f.data);
                    end
                    if (I_ACK) I_REQ = 1'b0;
                    if (D_ACK) D_REQ = 1'b0;
                end
            end
            total++;
            if (n != 2) begin
                bad++;
                $display("FAIL contention_pair%0d_count: acks=%0d, required 2", p, n);
                exp_q.delete();
                I_REQ = 1'b0; D_REQ = 1'b0;
            end
        end
        i_data_exp = ref_rd(2);
        d_data_exp = ref_rd(3);
    endtask

    task automatic test_write_read();
        exp_t e;
        bit got, o_i, o_d, o_err;
        int lat, c0;
        logic [31:0] idat, ddat;
        repeat (2) @(negedge CLK);
        c0 = cwe_cnt;
        e.is_d = 1'b1; e.data = d_data_exp; e.err = 1'b0; e.lat = 6 + miss_lat(22);
        exp_q.push_back(e);
        access(1'b1, 1'b1, 32'd22, 32'hFFFFE8CA, got, lat, o_i, o_d, o_err, idat, ddat);
        ref_v[22] = 1'b1; ref_m[22] = 32'hFFFFE8CA;
        e = exp_q.pop_front();
        total++;
        if (!got || !o_d || o_i || o_err || lat != e.lat || ddat !== e.data) begin
            bad++;
            $display("FAIL write_ack: got=%b D=%b I=%b ERR=%b lat=%0d D_DATA=%h, required 1 1 0 0 %0d %h",
                     got, o_d, o_i, o_err, lat, ddat, e.lat, e.data);
        end
        total++;
        if (cwe_cnt - c0 != 1) begin
            bad++;
            $display("FAIL write_we_pulses: got %0d, required 1", cwe_cnt - c0);
        end
        @(negedge CLK);
        e.is_d = 1'b1; e.data = ref_rd(22); e.err = 1'b0; e.lat = 3;
        exp_q.push_back(e);
        access(1'b1, 1'b0, 32'd22, 32'h0BADF00D, got, lat, o_i, o_d, o_err, idat, ddat);
        e = exp_q.pop_front();
        d_data_exp = e.data;
        total++;
        if (!got || !o_d || o_err || lat != e.lat || ddat !== e.data) begin
            bad++;
            $display("FAIL read_back: got=%b D=%b ERR=%b lat=%0d D_DATA=%h, required 1 1 0 %0d %h",
                     got, o_d, o_err, lat, ddat, e.lat, e.data);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (C_ADDR !== 32'd22 || C_DIN !== 32'h0BADF00D || cwe_cnt - c0 != 1) begin
            bad++;
            $display("FAIL idle_hold: C_ADDR=%h C_DIN=%h we=%0d, required 00000016 0badf00d 1",
                     C_ADDR, C_DIN, cwe_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit got, o_i, o_d, o_err;
        int lat;
        logic [31:0] idat, ddat;
        repeat (2) @(negedge CLK);
        for (int a = 0; a < 20; a++) begin
            e.is_d = 1'b0; e.data = ref_rd(a); e.err = 1'b0;
            e.lat = ((a == 0) ? 3 : 4) + miss_lat(a);
            exp_q.push_back(e);
            access(1'b0, 1'b0, 32'(a), 32'd0, got, lat, o_i, o_d, o_err, idat, ddat);
            e = exp_q.pop_front();
            total++;
            if (!got || !o_i || o_d || o_err || lat != e.lat || idat !== e.data) begin
                bad++;
                $display("FAIL ifetch_a%0d: got=%b I=%b D=%b ERR=%b lat=%0d I_DATA=%h, required 1 1 0 0 %0d %h",
                         a, got, o_i, o_d, o_err, lat, idat, e.lat, e.data);
            end
            i_data_exp = e.data;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            total++;
            if (I_ACK !== 1'b0 || I_DATA !== i_data_exp) begin
                bad++;
                $display("FAIL ifetch_after: I_ACK=%b I_DATA=%h, required 0 %h", I_ACK, I_DATA, i_data_exp);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit got, o_i, o_d, o_err;
        int lat;
        logic [31:0] idat, ddat;
        repeat (2) @(negedge CLK);
        force_low = 1'b1;
        e.is_d = 1'b1; e.data = d_data_exp; e.err = 1'b1; e.lat = 258;
        exp_q.push_back(e);
        access(1'b1, 1'b0, 32'd5, 32'd0, got, lat, o_i, o_d, o_err, idat, ddat);
        e = exp_q.pop_front();
        total++;
        if (!got || !o_d || o_err !== e.err || lat != e.lat || ddat !== e.data) begin
            bad++;
            $display("FAIL timeout: got=%b D=%b ERR=%b lat=%0d D_DATA=%h, required 1 1 1 %0d %h",
                     got, o_d, o_err, lat, ddat, e.lat, e.data);
        end
        force_low = 1'b0;
        @(negedge CLK);
        total++;
        if (BUSY !== 1'b0 || ERR !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: BUSY=%b ERR=%b, required 0 0", BUSY, ERR);
        end
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        bit found, got, o_i, o_d, o_err;
        int lat, acks;
        logic [31:0] idat, ddat;
        repeat (2) @(negedge CLK);
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'd7; D_DIN = 32'h12345678;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge CLK);
            if (C_WE === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rst_write_seen: C_WE never high, required a pulse");
        end
        #1 RST = 1'b1;
        #1;
        total++;
        if (C_WE !== 1'b0 || BUSY !== 1'b0 || D_ACK !== 1'b0) begin
            bad++;
            $display("FAIL rst_abort: C_WE=%b BUSY=%b D_ACK=%b, required 0 0 0", C_WE, BUSY, D_ACK);
        end
        D_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        i_data_exp = 32'd0;
        d_data_exp = 32'd0;
        acks = 0;
        repeat (5) begin
            @(negedge CLK);
            if (I_ACK || D_ACK) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL rst_no_ack: acks=%0d, required 0", acks);
        end
        e.is_d = 1'b1; e.data = ref_rd(7); e.err = 1'b0; e.lat = 3 + miss_lat(7);
        exp_q.push_back(e);
        access(1'b1, 1'b0, 32'd7, 32'd0, got, lat, o_i, o_d, o_err, idat, ddat);
        e = exp_q.pop_front();
        total++;
        if (!got || !o_d || o_err || lat != e.lat || ddat !== e.data) begin
            bad++;
            $display("FAIL rst_read_after: got=%b D=%b ERR=%b lat=%0d D_DATA=%h, required 1 1 0 %0d %h",
                     got, o_d, o_err, lat, ddat, e.lat, e.data);
        end
    endtask

    initial begin
        RST = 1'b1;
        I_REQ = 1'b0; I_ADDR = 32'd0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 32'd0; D_DIN = 32'd0;
        test_reset();
        test_contention();
        test_write_read();
        test_back_to_back();
        test_timeout();
        test_reset_mid_write();
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
